// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its UART sequencer.
// Opcode values and sequencer state encoding.
package alu_pkg;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] NOR = 6'b100111;

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    CAPTURE = ST_CAPTURE,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

endpackage

// File: rtl/alu_uart_interface_timer.sv
// Inter-byte idle counter; pulses expired on the last allowed idle cycle.
// TIMEOUT_CYCLES of 0 never expires.
module interbyte_timer #(
  parameter int NB_TIMEOUT     = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [NB_TIMEOUT-1:0] LAST =
    NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] cnt;

  assign expired = en && (TIMEOUT_CYCLES != 0)
                   && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || expired) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_uart_interface.sv
// Collects operand A, operand B and opcode from the UART receiver,
// drives the ALU and hands the registered result to the transmitter.
module alu_uart_interface
  import alu_pkg::*;
#(
  parameter int NB_DATA_BUS    = 8,
  parameter int NB_OPCODE      = 6,
  parameter int NB_TIMEOUT     = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_DATA_BUS-1:0] i_rx_data,
  input  logic                   i_rx_done,
  input  logic [NB_DATA_BUS-1:0] i_alu_result,
  input  logic                   i_tx_done,
  output logic [NB_DATA_BUS-1:0] o_first_operator,
  output logic [NB_DATA_BUS-1:0] o_second_operator,
  output logic [NB_OPCODE-1:0]   o_opcode,
  output logic [NB_DATA_BUS-1:0] o_tx_data,
  output logic                   o_tx_start,
  output logic                   o_busy,
  output logic                   o_overrun
);

  state_t state, state_nx;
  logic   tmr_en;
  logic   tmr_exp;
  logic   no_accept;

  interbyte_timer #(
    .NB_TIMEOUT    (NB_TIMEOUT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (i_clock),
    .rst_n  (i_reset),
    .clr    (~tmr_en),
    .en     (tmr_en),
    .expired(tmr_exp)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= WAIT_A;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    tmr_en    = 1'b0;
    no_accept = 1'b0;
    unique case (state)
      WAIT_A: begin
        if (i_rx_done) state_nx = WAIT_B;
      end
      WAIT_B: begin
        tmr_en = ~i_rx_done;
        if (i_rx_done)    state_nx = WAIT_OP;
        else if (tmr_exp) state_nx = WAIT_A;
      end
      WAIT_OP: begin
        tmr_en = ~i_rx_done;
        if (i_rx_done)    state_nx = CAPTURE;
        else if (tmr_exp) state_nx = WAIT_A;
      end
      CAPTURE: begin
        no_accept = 1'b1;
        state_nx  = SEND;
      end
      SEND: begin
        no_accept = 1'b1;
        state_nx  = WAIT_TX;
      end
      WAIT_TX: begin
        no_accept = 1'b1;
        if (i_tx_done) state_nx = WAIT_A;
      end
      default: state_nx = WAIT_A;
    endcase
  end

  // Operands hold across frames; they only move when a byte is taken.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_first_operator  <= '0;
      o_second_operator <= '0;
      o_opcode          <= '0;
      o_tx_data         <= '0;
      o_tx_start        <= 1'b0;
      o_overrun         <= 1'b0;
    end else begin
      o_tx_start <= (state == CAPTURE);
      if (state == WAIT_A && i_rx_done)
        o_first_operator <= i_rx_data;
      if (state == WAIT_B && i_rx_done)
        o_second_operator <= i_rx_data;
      if (state == WAIT_OP && i_rx_done)
        o_opcode <= i_rx_data[NB_OPCODE-1:0];
      if (state == CAPTURE)
        o_tx_data <= i_alu_result;
      if (no_accept && i_rx_done)
        o_overrun <= 1'b1;
    end
  end

  assign o_busy = (state != WAIT_A);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed and random frames against a behavioural ALU/sequencer model.
module tb_alu_uart_interface;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic [7:0] alu_res;
  logic       tx_done = 1'b0;
  logic [7:0] a_o, b_o, txd;
  logic [5:0] op_o;
  logic       start, busy, ovr;

  int total = 0;
  int bad = 0;

  logic [7:0] ma = '0, mb = '0, mtx = '0;
  logic [5:0] mop = '0;
  logic       movr = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(
    input logic [7:0] a, input logic [7:0] b,
    input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      SRA:     return sa >>> b;
      SRL:     return a >> b;
      NOR:     return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_res = ref_alu(a_o, b_o, op_o);

  alu_uart_interface #(
    .NB_DATA_BUS   (8),
    .NB_OPCODE     (6),
    .NB_TIMEOUT    (20),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst_n),
    .i_rx_data        (rx_data),
    .i_rx_done        (rx_done),
    .i_alu_result     (alu_res),
    .i_tx_done        (tx_done),
    .o_first_operator (a_o),
    .o_second_operator(b_o),
    .o_opcode         (op_o),
    .o_tx_data        (txd),
    .o_tx_start       (start),
    .o_busy           (busy),
    .o_overrun        (ovr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"},   a_o, 0);
    chk({tag, "_b"},   b_o, 0);
    chk({tag, "_op"},  op_o, 0);
    chk({tag, "_tx"},  txd, 0);
    chk({tag, "_st"},  start, 0);
    chk({tag, "_bsy"}, busy, 0);
    chk({tag, "_ovr"}, ovr, 0);
  endtask

  // Leaves the DUT in WAIT_TX when fin is 0.
  task automatic frame(input string tag,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] opb,
                       input int gap, input bit fin);
    send(a);
    repeat (gap) tick();
    send(b);
    repeat (gap) tick();
    send(opb);
    ma = a; mb = b; mop = opb[5:0];
    mtx = ref_alu(a, b, opb[5:0]);
    chk({tag, "_st0"}, start, 0);
    chk({tag, "_bsy"}, busy, 1);
    tick();
    chk({tag, "_st1"}, start, 1);
    chk({tag, "_tx"}, txd, mtx);
    chk({tag, "_a"}, a_o, ma);
    chk({tag, "_b"}, b_o, mb);
    chk({tag, "_op"}, op_o, mop);
    tick();
    chk({tag, "_st2"}, start, 0);
    if (fin) begin
      repeat (gap) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_ovr"}, ovr, movr);
    end
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [31:0] r;
    ops = '{ADD, SUB, AND, OR, XOR, SRA, SRL, NOR, 6'h3F};

    #12;
    chk_zero("rst");
    rst_n = 1'b1;
    tick();

    frame("add", 8'h05, 8'h03, 8'h20, 0, 1);
    chk("add_val", txd, 8'h08);
    frame("sub", 8'h03, 8'h05, 8'h22, 1, 1);
    chk("sub_val", txd, 8'hFE);
    frame("sra", 8'h80, 8'h02, 8'h03, 0, 1);
    chk("sra_val", txd, 8'hE0);
    frame("srl", 8'h80, 8'h02, 8'h02, 2, 1);
    chk("srl_val", txd, 8'h20);
    frame("undef", 8'h0F, 8'hF0, 8'h3F, 0, 1);
    chk("undef_val", txd, 8'h00);
    frame("hibits", 8'h21, 8'h12, 8'hE0, 0, 1);
    chk("hibits_op", op_o, 6'h20);

    // Fifteen idle cycles are tolerated, the sixteenth times out.
    send(8'h11);
    repeat (15) tick();
    chk("to_hold", busy, 1);
    tick();
    chk("to_bsy", busy, 0);
    chk("to_ovr", ovr, 0);
    chk("to_a", a_o, 8'h11);
    chk("to_b", b_o, mb);
    frame("post_to", 8'h01, 8'h01, 8'h20, 0, 1);
    chk("post_to_val", txd, 8'h02);

    frame("ov1", 8'h44, 8'h22, 8'h25, 0, 0);
    send(8'h77);
    movr = 1'b1;
    chk("ov_bsy", busy, 1);
    chk("ov_flag", ovr, 1);
    chk("ov_a", a_o, 8'h44);
    rx_data = 8'h99;
    rx_done = 1'b1;
    tx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tx_done = 1'b0;
    chk("ovc_bsy", busy, 0);
    chk("ovc_flag", ovr, 1);
    chk("ovc_a", a_o, 8'h44);
    frame("post_ov", 8'h30, 8'h0C, 8'h26, 0, 1);
    chk("post_ov_val", txd, 8'h3C);

    send(8'h55);
    send(8'h66);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    movr = 1'b0; ma = '0; mb = '0; mop = '0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    frame("pre_rst", 8'h12, 8'h34, 8'h20, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_tx");
    @(negedge clk) rst_n = 1'b1;
    tick();
    frame("and", 8'h0A, 8'h05, 8'h24, 0, 1);
    chk("and_val", txd, 8'h00);
    frame("or", 8'h0A, 8'h05, 8'h25, 0, 1);
    chk("or_val", txd, 8'h0F);

    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      frame("rnd", 8'($urandom), 8'($urandom),
            {r[7:6], ops[r % 9]}, int'(r[9:8]), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
Sequencer between the UART receiver/transmitter pair and the combinational ALU. It collects three received bytes in order: first operand, second operand, opcode. It drives them onto the ALU inputs, registers the ALU result and hands it to the UART transmitter through a start/done handshake. It is the operand producer and result consumer for the ALU.

Parameters:
NB_DATA_BUS, 8, width of operands, result, and UART rx/tx data.
NB_OPCODE, 6, width of the ALU opcode; taken from rx byte bits [NB_OPCODE-1:0].
NB_TIMEOUT, 20, width of the inter-byte timeout counter.
TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes of one frame; 0 disables the timeout.

Ports:
i_clock  in  1  system clock, rising edge.
i_reset  in  1  asynchronous, active-low reset.
i_rx_data  in  NB_DATA_BUS  byte from UART receiver; valid only while i_rx_done=1.
i_rx_done  in  1  one-cycle pulse, a new byte is available.
i_alu_result  in  NB_DATA_BUS  combinational result from the ALU.
i_tx_done  in  1  one-cycle pulse, transmitter finished the current byte.
o_first_operator  out  NB_DATA_BUS  ALU operand A (registered).
o_second_operator  out  NB_DATA_BUS  ALU operand B (registered).
o_opcode  out  NB_OPCODE  ALU opcode (registered).
o_tx_data  out  NB_DATA_BUS  byte to transmit (registered ALU result).
o_tx_start  out  1  one-cycle pulse, start transmission of o_tx_data.
o_busy  out  1  high in every state except WAIT_A.
o_overrun  out  1  sticky; a byte arrived while it could not be accepted.

Behaviour:
- Reset: i_reset=0 forces state WAIT_A, all outputs 0 and the timeout counter 0, immediately and asynchronously. This also applies mid-frame and mid-transmission; any partial frame is discarded.
- States: WAIT_A, WAIT_B, WAIT_OP, CAPTURE, SEND, WAIT_TX.
- WAIT_A, on i_rx_done: o_first_operator<=i_rx_data; go to WAIT_B.
- WAIT_B, on i_rx_done: o_second_operator<=i_rx_data; go to WAIT_OP.
- WAIT_OP, on i_rx_done: o_opcode<=i_rx_data[NB_OPCODE-1:0] (upper bits ignored); go to CAPTURE.
- CAPTURE: ALU inputs are stable for this cycle. At the edge ending it, o_tx_data<=i_alu_result; go to SEND.
- SEND: o_tx_start=1 for exactly this one cycle (registered output); go to WAIT_TX.
- WAIT_TX: stay until i_tx_done=1, then go to WAIT_A.
- Latency: with the opcode's i_rx_done in cycle T, o_tx_data is valid and o_tx_start=1 in cycle T+2.
- Undefined opcodes are not filtered; the ALU returns 0, so 0x00 is transmitted.
- Timeout: in WAIT_B and WAIT_OP the counter increments each cycle without i_rx_done and clears on i_rx_done.
  - When the count reaches TIMEOUT_CYCLES-1, go to WAIT_A.
  - Already-latched operands keep their values; o_overrun is not set.
  - The counter is cleared in every other state.
- Overrun: i_rx_done in CAPTURE, SEND or WAIT_TX drops the byte and sets o_overrun=1 until reset.
  - This includes i_rx_done coinciding with i_tx_done in WAIT_TX: go to WAIT_A and drop the byte.
- i_tx_done outside WAIT_TX is ignored.
- Operands and opcode hold their values between frames; they change only when the corresponding byte is accepted.

Decomposition:
- Shared package alu_pkg:
  - opcode constants ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111;
  - state encoding localparams for this FSM.
- One sub-module, interbyte_timer: load/clear, enable, expiry pulse, parameterised by NB_TIMEOUT and TIMEOUT_CYCLES.

Test Plan:
- Directed scenarios, bench with ALU instance, TIMEOUT_CYCLES=16:
  - Bytes 0x05, 0x03, 0x20 (ADD) -> o_tx_data=0x08, o_tx_start pulse 2 cycles after the third i_rx_done; after i_tx_done, o_busy=0.
  - Bytes 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE. Bytes 0x80, 0x02, 0x03 (SRA) -> 0xE0. Bytes 0x80, 0x02, 0x02 (SRL) -> 0x20.
  - Bytes 0x0F, 0xF0, 0x3F (undefined opcode) -> o_tx_data=0x00, o_tx_start still pulses once.
  - 0x11, then 16 idle cycles -> state WAIT_A, o_busy=0, o_overrun=0. Then 0x01, 0x01, 0x20 -> o_tx_data=0x02.
  - Extra byte during WAIT_TX, including one coincident with i_tx_done -> o_overrun=1; the next frame processes normally.
  - i_reset=0 after two bytes and again during WAIT_TX -> all outputs 0 immediately. After release, a full frame 0x0A, 0x05, 0x24 (AND) -> 0x00; 0x0A, 0x05, 0x25 (OR) -> 0x0F.
